// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM state encoding
// and frame constants.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int CLK_DIV_DEFAULT = 434;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POP   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLK_DIV-1 and flags the final cycle of each
// bit period; clear holds it at zero so every bit starts with a full period.
module uart_baud_gen #(
  parameter int CLK_DIV = 434
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic bit_tick
);

  localparam int              CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign bit_tick = !clear && (r_cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clear || bit_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_fifo_tx.sv
// UART transmitter that pops bytes from an upstream sync FIFO and sends
// 8N1 frames, LSB first, with a registered serial output.
//
// state | meaning
// IDLE  | line high, waiting for enable with a non-empty FIFO
// POP   | one-cycle FIFO read strobe
// LOAD  | FIFO read data captured into the shift register
// START | start bit (low) for one bit period
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); tx_done on its last cycle
module uart_fifo_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      fifo_empty,
  input  logic [UART_DATA_BITS-1:0] fifo_data,
  output logic                      fifo_rd_en,
  output logic                      tx,
  output logic                      busy,
  output logic                      tx_done
);

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_state_e               r_state;
  uart_state_e               w_state_next;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [2:0]                r_bit_idx;
  logic [2:0]                w_bit_idx_next;
  logic                      r_tx;
  logic                      w_tx_next;
  logic                      w_clear;
  logic                      w_bit_tick;

  // Baud timer only runs while a bit is on the line, so it enters START at zero.
  assign w_clear = (r_state == ST_IDLE) || (r_state == ST_POP) || (r_state == ST_LOAD);

  uart_baud_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (w_clear),
    .bit_tick (w_bit_tick)
  );

  always_comb begin
    w_state_next   = r_state;
    w_bit_idx_next = r_bit_idx;
    case (r_state)
      ST_IDLE:  if (enable && !fifo_empty) w_state_next = ST_POP;
      ST_POP:   w_state_next = ST_LOAD;
      ST_LOAD:  w_state_next = ST_START;
      ST_START: begin
        if (w_bit_tick) begin
          w_state_next   = ST_DATA;
          w_bit_idx_next = '0;
        end
      end
      ST_DATA: begin
        if (w_bit_tick) begin
          if (r_bit_idx == LAST_BIT) w_state_next = ST_STOP;
          else                       w_bit_idx_next = r_bit_idx + 3'd1;
        end
      end
      ST_STOP:  if (w_bit_tick) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Line level is decided from the next state so the register lines up with it.
  always_comb begin
    w_tx_next = 1'b1;
    case (w_state_next)
      ST_START: w_tx_next = 1'b0;
      ST_DATA:  w_tx_next = r_shift[w_bit_idx_next];
      default:  w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_bit_idx <= w_bit_idx_next;
      r_tx      <= w_tx_next;
      if (r_state == ST_LOAD) r_shift <= fifo_data;
    end
  end

  assign fifo_rd_en = (r_state == ST_POP);
  assign busy       = (r_state != ST_IDLE);
  assign tx_done    = (r_state == ST_STOP) && w_bit_tick;
  assign tx         = r_tx;

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Bench for uart_fifo_tx: FIFO model, frame-timeline reference model checked
// every cycle, a UART receiver, and directed scenarios with literal expectations.
module tb_uart_fifo_tx;
  import uart_pkg::*;

  localparam int CLK_DIV   = 4;
  localparam int FRAME_LEN = 10 * CLK_DIV + 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;
  logic       tx_done;

  uart_fifo_tx #(.CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rd_cnt  = 0;
  int done_cnt = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic [9:0] rx_frame_q[$];
  int         rx_start_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
  endtask

  // Upstream FIFO: registered empty flag and read data.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
    fifo_empty <= (fifo_q.size() == 0);
    if (fifo_rd_en) rd_cnt <= rd_cnt + 1;
    if (tx_done) done_cnt <= done_cnt + 1;
  end

  // Reference: a frame is a fixed timeline of FRAME_LEN cycles starting with the pop.
  logic       m_active = 1'b0;
  int         m_t = 0;
  logic [7:0] m_byte = 8'h00;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active <= 1'b0;
      m_t      <= 0;
    end else if (!m_active) begin
      if (enable && !fifo_empty && exp_q.size() > 0) begin
        m_active <= 1'b1;
        m_t      <= 0;
        m_byte   <= exp_q.pop_front();
      end
    end else if (m_t == FRAME_LEN - 1) begin
      m_active <= 1'b0;
    end else begin
      m_t <= m_t + 1;
    end
  end

  logic prev_rd = 1'b0;

  always @(negedge clk) begin
    logic e_tx, e_busy, e_rd, e_done;
    int   k;
    if (reset_n) begin
      e_tx = 1'b1; e_busy = 1'b0; e_rd = 1'b0; e_done = 1'b0;
      if (m_active) begin
        e_busy = 1'b1;
        e_rd   = (m_t == 0);
        e_done = (m_t == FRAME_LEN - 1);
        if (m_t >= 2) begin
          k = (m_t - 2) / CLK_DIV;
          if (k == 0)      e_tx = 1'b0;
          else if (k <= 8) e_tx = m_byte[k-1];
        end
      end
      chk("model_tx", tx, e_tx);
      chk("model_busy", busy, e_busy);
      chk("model_rd_en", fifo_rd_en, e_rd);
      chk("model_tx_done", tx_done, e_done);
      chk("rd_when_empty", fifo_rd_en & fifo_empty, 1'b0);
      chk("rd_back_to_back", fifo_rd_en & prev_rd, 1'b0);
      chk("done_outside_stop", tx_done & (dut.r_state != ST_STOP), 1'b0);
      prev_rd = fifo_rd_en;
    end else begin
      prev_rd = 1'b0;
    end
  end

  // Independent receiver: samples mid-bit after each falling edge of tx.
  initial begin
    forever begin
      @(negedge tx);
      if (reset_n) begin
        logic [9:0] f;
        int         st;
        @(posedge clk);
        st = cyc;
        repeat (CLK_DIV/2 - 1) @(posedge clk);
        f[0] = tx;
        for (int i = 1; i < 10; i++) begin
          repeat (CLK_DIV) @(posedge clk);
          f[i] = tx;
        end
        rx_frame_q.push_back(f);
        rx_q.push_back(f[8:1]);
        rx_start_q.push_back(st);
      end
    end
  end

  task automatic check_rx(input string name, input logic [7:0] exp);
    chk({name, "_present"}, rx_q.size() > 0, 1'b1);
    if (rx_q.size() > 0) chk(name, rx_q.pop_front(), exp);
  endtask

  task automatic wait_rd(input string name);
    int n = 0;
    while (!fifo_rd_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, fifo_rd_en, 1'b1);
  endtask

  initial begin
    int r0, d0, txlow, bsy, s0, s1, s2;
    reset_n = 1'b0;
    enable  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd_en", fifo_rd_en, 1'b0);
    chk("rst_tx_done", tx_done, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single byte 0xA5
    r0 = rd_cnt; d0 = done_cnt;
    push(8'hA5);
    enable = 1'b1;
    repeat (60) @(negedge clk);
    chk("a5_rd_pulses", rd_cnt - r0, 1);
    chk("a5_tx_done_pulses", done_cnt - d0, 1);
    chk("a5_busy_after", busy, 1'b0);
    chk("a5_frame_present", rx_frame_q.size() > 0, 1'b1);
    if (rx_frame_q.size() > 0) chk("a5_frame_bits", rx_frame_q.pop_front(), 10'b1101001010);
    check_rx("a5_rx_byte", 8'hA5);
    rx_start_q.delete();

    // Back-to-back 0x00, 0xFF, 0x3C
    r0 = rd_cnt;
    push(8'h00); push(8'hFF); push(8'h3C);
    repeat (3 * 43 + 20) @(negedge clk);
    chk("b2b_rd_pulses", rd_cnt - r0, 3);
    check_rx("b2b_rx0", 8'h00);
    check_rx("b2b_rx1", 8'hFF);
    check_rx("b2b_rx2", 8'h3C);
    chk("b2b_starts", rx_start_q.size(), 3);
    if (rx_start_q.size() == 3) begin
      s0 = rx_start_q.pop_front(); s1 = rx_start_q.pop_front(); s2 = rx_start_q.pop_front();
      chk("b2b_gap01", s1 - s0, 43);
      chk("b2b_gap12", s2 - s1, 43);
    end
    rx_frame_q.delete(); rx_start_q.delete();

    // Empty FIFO with enable held high
    r0 = rd_cnt; txlow = 0; bsy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!tx) txlow++;
      if (busy) bsy++;
    end
    chk("empty_rd_pulses", rd_cnt - r0, 0);
    chk("empty_tx_low_cycles", txlow, 0);
    chk("empty_busy_cycles", bsy, 0);

    // Enable dropped during data bits of 0x55
    r0 = rd_cnt;
    push(8'h55); push(8'h66);
    wait_rd("drop_first_pop");
    repeat (12) @(negedge clk);
    enable = 1'b0;
    repeat (80) @(negedge clk);
    chk("drop_rd_pulses", rd_cnt - r0, 1);
    check_rx("drop_rx_55", 8'h55);
    chk("drop_busy", busy, 1'b0);
    chk("drop_fifo_left", fifo_q.size(), 1);
    enable = 1'b1;
    repeat (60) @(negedge clk);
    chk("drop_rd_pulses_after", rd_cnt - r0, 2);
    check_rx("drop_rx_66", 8'h66);
    rx_frame_q.delete(); rx_start_q.delete();

    // Reset during bit 3 of 0x81
    push(8'h81);
    wait_rd("rst_mid_pop");
    repeat (20) @(negedge clk);
    chk("rst_mid_tx_bit3", tx, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_tx_async", tx, 1'b1);
    chk("rst_mid_busy_async", busy, 1'b0);
    chk("rst_mid_rd_async", fifo_rd_en, 1'b0);
    r0 = rd_cnt;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("rst_no_reads", rd_cnt - r0, 0);
    chk("rst_idle_tx", tx, 1'b1);
    rx_q.delete(); rx_frame_q.delete(); rx_start_q.delete();
    push(8'h42);
    repeat (60) @(negedge clk);
    chk("rst_after_rd_pulses", rd_cnt - r0, 1);
    check_rx("rst_after_rx_42", 8'h42);
    chk("rst_after_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/uart_fifo_tx.md
UART_FIFO_TX -- requirements
Module: uart_fifo_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 434, clock cycles per UART bit; legal range 2..65535.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port enable  input  1  permits starting a new frame; sampled only in IDLE.
REQ-005 SHALL have port fifo_empty  input  1  empty flag of the upstream 8-bit sync FIFO.
REQ-006 SHALL have port fifo_data  input  8  FIFO read data, valid the cycle after a read strobe.
REQ-007 SHALL have port fifo_rd_en  output  1  one-cycle FIFO read strobe.
REQ-008 SHALL have port tx  output  1  serial line, idle high.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port tx_done  output  1  one-cycle pulse at end of each frame's stop bit.

Function
REQ-011 SHALL implement states IDLE, POP, LOAD, START, DATA, STOP.
REQ-012 IDLE -> POP SHALL occur when enable=1 and fifo_empty=0; otherwise remain IDLE.
REQ-013 fifo_rd_en SHALL be 1 exactly in POP (one cycle) and 0 in all other states; no back-to-back strobes.
REQ-014 POP -> LOAD unconditionally; in LOAD the shift register SHALL capture fifo_data; LOAD -> START.
REQ-015 START SHALL drive tx=0 for CLK_DIV cycles, then -> DATA.
REQ-016 DATA SHALL drive 8 bits LSB first, each for exactly CLK_DIV cycles; bit index 0..7, then -> STOP.
REQ-017 STOP SHALL drive tx=1 for CLK_DIV cycles; tx_done=1 in the final STOP cycle; then -> IDLE.
REQ-018 tx SHALL be 1 in IDLE, POP, LOAD; tx SHALL be driven from a register (no glitches).
REQ-019 Frame time on tx SHALL be exactly 10*CLK_DIV cycles; start-to-start for back-to-back bytes SHALL be 10*CLK_DIV+3 cycles.
REQ-020 Baud counter SHALL be $clog2(CLK_DIV) bits wide, count 0..CLK_DIV-1, reload to 0 on every bit boundary and state entry.
REQ-021 enable deasserted mid-frame SHALL NOT abort the frame; the current byte completes, then stays IDLE.
REQ-022 fifo_empty rising after POP SHALL NOT affect the captured byte or the frame.
REQ-023 fifo_empty and enable SHALL be ignored outside IDLE.

Reset
REQ-024 reset_n=0 SHALL immediately force state IDLE, tx=1, fifo_rd_en=0, busy=0, tx_done=0, counters and shift register 0.
REQ-025 Reset mid-frame SHALL abort the frame with no further FIFO reads; after release, start requires REQ-012 again.
REQ-026 First possible fifo_rd_en after reset release SHALL be the first clock edge with reset_n=1 sampled.

Structure
REQ-027 Shared package uart_pkg SHALL hold the state enumeration (3-bit encoding), UART_DATA_BITS=8 and the default CLK_DIV constant.
REQ-028 One sub-module uart_baud_gen (counter, CLK_DIV parameter, clear input, bit_tick output) SHALL generate bit boundaries; FSM and shifter stay in uart_fifo_tx.

Verification (CLK_DIV=4, FIFO model with registered read data)
REQ-029 Single byte: push 0xA5, enable=1 -> one fifo_rd_en pulse; tx = 0,1,0,1,0,0,1,0,1,1 each 4 cycles (40 cycles); tx_done once; busy low afterward.
REQ-030 Back-to-back: push 0x00,0xFF,0x3C -> three rd pulses, frames start 43 cycles apart, bytes decoded by a bench UART receiver in order.
REQ-031 Empty FIFO: enable=1, fifo_empty=1 for 100 cycles -> fifo_rd_en never asserted, tx=1, busy=0.
REQ-032 Enable drop: push 0x55,0x66; deassert enable during 0x55 data bits -> 0x55 completes, 0x66 not popped until enable re-asserted.
REQ-033 Reset mid-frame: assert reset_n=0 during bit 3 of 0x81 -> tx=1 and busy=0 in the same cycle asynchronously; after release, next pushed byte 0x42 is sent correctly.
REQ-034 Bench assertions: fifo_rd_en never high when fifo_empty=1; never two consecutive rd cycles; tx_done only when state STOP.
